// File: rtl/filter_preload_buffer.sv
// Filter preload buffer: bulk-loads filter words from RAM over a single-beat Wishbone master
// into a local word buffer with a 1-cycle read port. Define FILTER_PRELOAD_CHECKSUM_EN to build the load checksum.
module filter_preload_buffer #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 10,
   parameter int MAX_RETRY   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [31:0]       start_base,
   input  logic [ADDR_W:0]   start_len,
   output logic              busy,
   output logic              done,
   output logic              load_err,
   output logic [ADDR_W:0]   loaded_count,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       rd_data,
   output logic              rd_hit,
   output logic [31:0]       checksum,
   output logic [29:0]       wb_adr,
   output logic              wb_cyc,
   output logic              wb_stb,
   output logic              wb_we,
   output logic [3:0]        wb_sel,
   output logic [2:0]        wb_cti,
   output logic [1:0]        wb_bte,
   input  logic [31:0]       wb_dat_miso,
   input  logic              wb_ack,
   input  logic              wb_err
);
   // state | meaning
   // IDLE  | waiting for a load request
   // FETCH | bus cycle for word idx in flight
   // GAP   | one idle bus cycle between attempts
   // DONE  | one-cycle completion pulse
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_GAP, S_DONE} state_t;

   localparam int                RETRY_W = $clog2(MAX_RETRY + 1);
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH_WORDS);
   localparam logic [ADDR_W:0]   ONE     = 1;

   state_t             state, state_nxt;
   logic [29:0]        base_q;
   logic [ADDR_W:0]    len_q;
   logic [RETRY_W-1:0] retry_q;
   logic [ADDR_W:0]    len_clamped;
   logic               start_fire;
   logic               last_word;
   logic               retry_full;
   logic [31:0]        mem [DEPTH_WORDS];

   assign start_ready = (state == S_IDLE);
   assign busy        = (state == S_FETCH) || (state == S_GAP);
   assign done        = (state == S_DONE);
   assign wb_cyc      = (state == S_FETCH);
   assign wb_stb      = (state == S_FETCH);
   assign wb_we       = 1'b0;
   assign wb_sel      = 4'hF;
   assign wb_cti      = 3'b000;
   assign wb_bte      = 2'b00;

   // loaded_count doubles as the fetch index: it only advances on ack.
   assign wb_adr      = base_q + 30'(loaded_count);
   assign start_fire  = start_valid && start_ready;
   assign len_clamped = (start_len > DEPTH_L) ? DEPTH_L : start_len;
   assign last_word   = ((loaded_count + ONE) == len_q);
   assign retry_full  = (retry_q == RETRY_W'(MAX_RETRY));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_fire) state_nxt = (len_clamped == '0) ? S_DONE : S_FETCH;
         S_FETCH: begin
            if (wb_ack)      state_nxt = last_word ? S_DONE : S_GAP;
            else if (wb_err) state_nxt = retry_full ? S_DONE : S_GAP;
         end
         S_GAP:   state_nxt = S_FETCH;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q       <= '0;
         len_q        <= '0;
         loaded_count <= '0;
         retry_q      <= '0;
         load_err     <= 1'b0;
         rd_hit       <= 1'b0;
      end else begin
         if (start_fire) begin
            base_q       <= start_base[31:2];
            len_q        <= len_clamped;
            loaded_count <= '0;
            retry_q      <= '0;
            load_err     <= 1'b0;
         end else if (state == S_FETCH) begin
            if (wb_ack) begin
               loaded_count <= loaded_count + ONE;
               retry_q      <= '0;
            end else if (wb_err) begin
               if (retry_full) load_err <= 1'b1;
               else            retry_q  <= retry_q + 1'b1;
            end
         end
         // A word written this cycle is not yet counted, so a same-cycle read misses.
         rd_hit <= rd_en && ({1'b0, rd_addr} < loaded_count);
      end
   end

   always_ff @(posedge clk) begin
      if ((state == S_FETCH) && wb_ack) mem[loaded_count[ADDR_W-1:0]] <= wb_dat_miso;
      if (rd_en) rd_data <= mem[rd_addr];
   end

`ifdef FILTER_PRELOAD_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                             checksum <= '0;
      else if (start_fire)                    checksum <= '0;
      else if ((state == S_FETCH) && wb_ack)  checksum <= checksum + wb_dat_miso;
   end
`else
   assign checksum = '0;
`endif

endmodule
